// File: rtl/clkreq_seq.sv
// -----------------------------------------------------------------------------
// clkreq_seq -- requester end of the dual-clock (HS/LS) switch handshake.
//
// Runs on the CPU clock. Decodes whether each bus cycle needs the slow (LS)
// clock, requests HS or LS from the clock controller, waits for the
// controller's synchronised "selected" status, stalls the CPU through RDY
// while a switch to LS completes, and lingers in LS for HOLD_CYCLES
// non-slow cycles before asking for HS again.
//
// Optional feature: define CLKREQ_SWITCH_CNT_EN to build the 16-bit
// completed-switch counter; otherwise switch_cnt_out is tied to zero.
//
// Parameters:
//   SYNC_STAGES  flops per status-input synchroniser (>= 2)
//   HOLD_CYCLES  consecutive non-slow LS cycles before requesting HS (>= 1)
//   TIMEOUT      cycles allowed per handshake before timeout_err_out is set
//
// Ports:
//   cpuclk_in          CPU clock (switched clock from the controller)
//   rst                asynchronous active-high reset
//   hs_en_in           high-speed mode permitted
//   cycle_valid_in     current cycle is a valid bus access
//   slow_access_in     access targets LS-only space (qualified by valid)
//   hsclk_selected_in  controller status: HS selected (asynchronous)
//   lsclk_selected_in  controller status: LS selected (asynchronous)
//   hsclk_sel_out      clock request, 1 = HS, 0 = LS
//   rdy_out            CPU RDY, 0 stalls the current cycle
//   timeout_err_out    sticky handshake-timeout flag
//   state_out          current FSM state encoding
//   switch_cnt_out     completed switch count (optional feature)
// -----------------------------------------------------------------------------
module clkreq_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic        cpuclk_in,
    input  logic        rst,
    input  logic        hs_en_in,
    input  logic        cycle_valid_in,
    input  logic        slow_access_in,
    input  logic        hsclk_selected_in,
    input  logic        lsclk_selected_in,
    output logic        hsclk_sel_out,
    output logic        rdy_out,
    output logic        timeout_err_out,
    output logic [2:0]  state_out,
    output logic [15:0] switch_cnt_out
);

    typedef enum logic [2:0] {
        LS_RUN = 3'b001,
        REQ_HS = 3'b010,
        HS_RUN = 3'b011,
        REQ_LS = 3'b100
    } state_t;

    // The handshake counter doubles as the "time spent in REQ_LS" measure,
    // so it must be able to reach both TIMEOUT and SYNC_STAGES.
    localparam int TMAX = (TIMEOUT > SYNC_STAGES) ? TIMEOUT : SYNC_STAGES;
    localparam int LW   = $clog2(HOLD_CYCLES + 1);
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [LW-1:0] HOLD_L   = LW'(HOLD_CYCLES);
    localparam logic [TW-1:0] TMO_L    = TW'(TIMEOUT);
    localparam logic [TW-1:0] SETTLE_L = TW'(SYNC_STAGES);
    localparam logic [TW-1:0] TMAX_L   = TW'(TMAX);

    state_t                 state_q, state_d;
    logic                   hsclk_sel_q, hsclk_sel_d;
    logic [LW-1:0]          linger_q, linger_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic                   tmo_err_q, tmo_err_d;
    logic [SYNC_STAGES-1:0] hs_sync_q, ls_sync_q;
    logic                   hs_sync, ls_sync;
    logic                   slow;
    logic                   rdy;
    logic [TW-1:0]          tmo_inc;

    assign slow    = cycle_valid_in & slow_access_in;
    assign hs_sync = hs_sync_q[SYNC_STAGES-1];
    assign ls_sync = ls_sync_q[SYNC_STAGES-1];
    assign tmo_inc = (tmo_q == TMAX_L) ? tmo_q : tmo_q + 1'b1;

    // Status synchronisers: stage 0 samples the asynchronous input.
    always_ff @(posedge cpuclk_in or posedge rst) begin
        if (rst) begin
            hs_sync_q <= '0;
            ls_sync_q <= '0;
        end else begin
            hs_sync_q <= {hs_sync_q[SYNC_STAGES-2:0], hsclk_selected_in};
            ls_sync_q <= {ls_sync_q[SYNC_STAGES-2:0], lsclk_selected_in};
        end
    end

    always_ff @(posedge cpuclk_in or posedge rst) begin
        if (rst) begin
            state_q     <= LS_RUN;
            hsclk_sel_q <= 1'b0;
            linger_q    <= '0;
            tmo_q       <= '0;
            tmo_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hsclk_sel_q <= hsclk_sel_d;
            linger_q    <= linger_d;
            tmo_q       <= tmo_d;
            tmo_err_q   <= tmo_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        linger_d  = '0;
        tmo_d     = '0;
        tmo_err_d = tmo_err_q;
        rdy       = 1'b1;
        case (state_q)
            LS_RUN: begin
                // Slow access beats an expired linger window.
                if (slow) begin
                    linger_d = '0;
                end else if (linger_q == HOLD_L && hs_en_in) begin
                    state_d = REQ_HS;
                end else if (linger_q != HOLD_L) begin
                    linger_d = linger_q + 1'b1;
                end else begin
                    linger_d = linger_q;
                end
            end
            REQ_HS: begin
                tmo_d = tmo_inc;
                // Abort beats completion; completion beats timeout.
                if (slow || !hs_en_in) begin
                    state_d = REQ_LS;
                end else if (hs_sync && !ls_sync) begin
                    state_d = HS_RUN;
                end else if (tmo_q >= TMO_L) begin
                    tmo_err_d = 1'b1;
                    state_d   = LS_RUN;
                end
            end
            HS_RUN: begin
                rdy = !slow;
                if (slow || !hs_en_in) begin
                    state_d = REQ_LS;
                end
            end
            REQ_LS: begin
                rdy   = 1'b0;
                tmo_d = tmo_inc;
                // Status seen in the first SYNC_STAGES cycles may predate the
                // request, so it is ignored. A timeout only flags: the CPU is
                // never released until LS is actually confirmed.
                if (ls_sync && !hs_sync && tmo_q >= SETTLE_L) begin
                    state_d = LS_RUN;
                end else if (tmo_q >= TMO_L) begin
                    tmo_err_d = 1'b1;
                end
            end
            default: begin
                state_d = LS_RUN;
            end
        endcase
        // Handshake counter restarts on every state entry.
        if (state_d != state_q) begin
            tmo_d = '0;
        end
    end

    assign hsclk_sel_d = (state_d == REQ_HS) || (state_d == HS_RUN);

    assign hsclk_sel_out   = hsclk_sel_q;
    assign rdy_out         = rdy;
    assign timeout_err_out = tmo_err_q;
    assign state_out       = state_q;

`ifdef CLKREQ_SWITCH_CNT_EN
    logic [15:0] switch_cnt_q;
    logic        switch_done;

    assign switch_done = ((state_q == REQ_HS) && (state_d == HS_RUN)) ||
                         ((state_q == REQ_LS) && (state_d == LS_RUN));

    always_ff @(posedge cpuclk_in or posedge rst) begin
        if (rst) begin
            switch_cnt_q <= 16'h0000;
        end else if (switch_done && switch_cnt_q != 16'hFFFF) begin
            switch_cnt_q <= switch_cnt_q + 16'd1;
        end
    end

    assign switch_cnt_out = switch_cnt_q;
`else
    assign switch_cnt_out = 16'h0000;
`endif

endmodule

// File: tb/tb_clkreq_seq.sv
module tb_clkreq_seq;

    localparam int S = 2;
    localparam int H = 4;
    localparam int T = 64;

    localparam int ST_LS_RUN = 1;
    localparam int ST_REQ_HS = 2;
    localparam int ST_HS_RUN = 3;
    localparam int ST_REQ_LS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hs_en = 1'b0;
    logic        cv = 1'b0;
    logic        sa = 1'b0;
    logic        hs_st = 1'b0;
    logic        ls_st = 1'b0;
    logic        sel_o;
    logic        rdy_o;
    logic        err_o;
    logic [2:0]  state_o;
    logic [15:0] cnt_o;

    int total = 0;
    int bad   = 0;
    int step_no = 0;

    // Reference model: plain counters describing the requester's rules.
    int m_st;
    int m_linger;   // consecutive non-slow cycles seen in LS_RUN (capped at H)
    int m_time;     // cycles already spent in the current state
    bit m_err;
    int m_cnt;
    bit hs_pipe[S];
    bit ls_pipe[S];
    bit sel_hist[8];  // sel_hist[k] = expected request k cycles ago

    // Clock-controller stand-in: status follows the request after ctl_dly
    // cycles, with a break-before-make gap, unless stuck.
    int ctl_dly = 3;
    bit ctl_stuck = 1'b0;

    always #5 clk = ~clk;

    clkreq_seq #(
        .SYNC_STAGES(S),
        .HOLD_CYCLES(H),
        .TIMEOUT(T)
    ) dut (
        .cpuclk_in(clk),
        .rst(rst),
        .hs_en_in(hs_en),
        .cycle_valid_in(cv),
        .slow_access_in(sa),
        .hsclk_selected_in(hs_st),
        .lsclk_selected_in(ls_st),
        .hsclk_sel_out(sel_o),
        .rdy_out(rdy_o),
        .timeout_err_out(err_o),
        .state_out(state_o),
        .switch_cnt_out(cnt_o)
    );

    function automatic bit exp_sel();
        return (m_st == ST_REQ_HS) || (m_st == ST_HS_RUN);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d (step %0d)", tag, obs, expv, step_no);
        end
    endtask

    task automatic model_reset();
        m_st = ST_LS_RUN;
        m_linger = 0;
        m_time = 0;
        m_err = 1'b0;
        m_cnt = 0;
        for (int i = 0; i < S; i++) begin
            hs_pipe[i] = 1'b0;
            ls_pipe[i] = 1'b0;
        end
        for (int i = 0; i < 8; i++) sel_hist[i] = 1'b0;
    endtask

    // Called just after a rising edge; leaves just after the next one.
    task automatic step(input bit v, input bit s, input bit en);
        bit slow;
        bit hs_sync;
        bit ls_sync;
        bit done;
        int nxt;
        bit exp_rdy;
        if (ctl_stuck) begin
            hs_st = 1'b0;
            ls_st = 1'b0;
        end else begin
            hs_st = sel_hist[ctl_dly] & sel_hist[ctl_dly-1];
            ls_st = !sel_hist[ctl_dly] & !sel_hist[ctl_dly-1];
        end
        cv = v;
        sa = s;
        hs_en = en;
        slow = v & s;
        step_no++;
        @(negedge clk);
        exp_rdy = (m_st == ST_REQ_LS) ? 1'b0 : (m_st == ST_HS_RUN) ? !slow : 1'b1;
        chk("state", 32'(state_o), 32'(m_st));
        chk("hsclk_sel", 32'(sel_o), 32'(exp_sel()));
        chk("rdy", 32'(rdy_o), 32'(exp_rdy));
        chk("timeout_err", 32'(err_o), 32'(m_err));
        chk("switch_cnt", 32'(cnt_o), 32'(m_cnt));
        $display("step %0d v=%0b s=%0b en=%0b hs=%0b ls=%0b state=%0d sel=%0b rdy=%0b err=%0b cnt=%0d",
                 step_no, v, s, en, hs_st, ls_st, state_o, sel_o, rdy_o, err_o, cnt_o);
        @(posedge clk);
        hs_sync = hs_pipe[S-1];
        ls_sync = ls_pipe[S-1];
        nxt = m_st;
        done = 1'b0;
        case (m_st)
            ST_LS_RUN: begin
                if (slow) m_linger = 0;
                else if (m_linger >= H && en) nxt = ST_REQ_HS;
                else if (m_linger < H) m_linger++;
            end
            ST_REQ_HS: begin
                if (slow || !en) nxt = ST_REQ_LS;
                else if (hs_sync && !ls_sync) begin nxt = ST_HS_RUN; done = 1'b1; end
                else if (m_time >= T) begin m_err = 1'b1; nxt = ST_LS_RUN; end
            end
            ST_HS_RUN: begin
                if (slow || !en) nxt = ST_REQ_LS;
            end
            ST_REQ_LS: begin
                if (ls_sync && !hs_sync && m_time >= S) begin nxt = ST_LS_RUN; done = 1'b1; end
                else if (m_time >= T) m_err = 1'b1;
            end
            default: nxt = ST_LS_RUN;
        endcase
        if (nxt != m_st) begin
            m_time = 0;
            m_linger = 0;
        end else if (m_time < 1000) begin
            m_time++;
        end
`ifdef CLKREQ_SWITCH_CNT_EN
        if (done && m_cnt < 16'hFFFF) m_cnt++;
`endif
        m_st = nxt;
        for (int i = S - 1; i > 0; i--) begin
            hs_pipe[i] = hs_pipe[i-1];
            ls_pipe[i] = ls_pipe[i-1];
        end
        hs_pipe[0] = hs_st;
        ls_pipe[0] = ls_st;
        for (int i = 7; i > 0; i--) sel_hist[i] = sel_hist[i-1];
        sel_hist[0] = exp_sel();
        #1;
    endtask

    // Asserts reset between edges and checks the outputs before any clock
    // edge, then releases it just after the following edge.
    task automatic do_reset();
        cv = 1'b0;
        sa = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_state", 32'(state_o), 32'(ST_LS_RUN));
        chk("rst_sel", 32'(sel_o), 32'd0);
        chk("rst_rdy", 32'(rdy_o), 32'd1);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_cnt", 32'(cnt_o), 32'd0);
        $display("reset applied state=%0d sel=%0b err=%0b", state_o, sel_o, err_o);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int guard;
        bit saw_sel;
        model_reset();
        #2;
        do_reset();

        // HS entry with no slow traffic.
        ctl_dly = 3;
        for (int i = 0; i < 20; i++) step(1'($urandom % 2), 1'b0, 1'b1);
        chk("hs_entry_state", 32'(state_o), 32'(ST_HS_RUN));

        // Slow access from HS_RUN: stall until LS confirmed.
        step(1'b1, 1'b1, 1'b1);
        chk("to_ls_sel", 32'(sel_o), 32'd0);
        chk("to_ls_state", 32'(state_o), 32'(ST_REQ_LS));
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 1'b0);
        chk("back_ls_state", 32'(state_o), 32'(ST_LS_RUN));

        // Abort while HS request pending.
        guard = 0;
        while (m_st != ST_REQ_HS && guard < 50) begin
            step(1'b0, 1'b0, 1'b1);
            guard++;
        end
        chk("req_hs_reached", 32'(state_o), 32'(ST_REQ_HS));
        step(1'b1, 1'b1, 1'b1);
        chk("abort_state", 32'(state_o), 32'(ST_REQ_LS));
        chk("abort_sel", 32'(sel_o), 32'd0);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b0);
        chk("abort_done", 32'(state_o), 32'(ST_LS_RUN));

        // Controller never answers: timeout.
        ctl_stuck = 1'b1;
        guard = 0;
        while (!m_err && guard < 200) begin
            step(1'b0, 1'b0, 1'b1);
            guard++;
        end
        chk("tmo_err", 32'(err_o), 32'd1);
        chk("tmo_state", 32'(state_o), 32'(ST_LS_RUN));
        chk("tmo_sel", 32'(sel_o), 32'd0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1);
        chk("tmo_sticky", 32'(err_o), 32'd1);
        ctl_stuck = 1'b0;

        // Slow access every third cycle keeps the linger window from expiring.
        do_reset();
        saw_sel = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step(1'b1, (i % 3) == 0, 1'b1);
            saw_sel = saw_sel | sel_o;
        end
        chk("no_hs_request", 32'(saw_sel), 32'd0);

        // Three full round trips.
        for (int trip = 0; trip < 3; trip++) begin
            guard = 0;
            while (m_st != ST_HS_RUN && guard < 100) begin
                step(1'b1, 1'b0, 1'b1);
                guard++;
            end
            chk("trip_hs", 32'(state_o), 32'(ST_HS_RUN));
            step(1'b1, 1'b1, 1'b1);
            guard = 0;
            while (m_st != ST_LS_RUN && guard < 100) begin
                step(1'b1, 1'b0, 1'b1);
                guard++;
            end
            chk("trip_ls", 32'(state_o), 32'(ST_LS_RUN));
        end
`ifdef CLKREQ_SWITCH_CNT_EN
        chk("trip_count", 32'(cnt_o), 32'd6);
`else
        chk("trip_count", 32'(cnt_o), 32'd0);
`endif

        // Randomised traffic, controller delays and stuck episodes.
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) ctl_dly = int'($urandom_range(1, 4));
            ctl_stuck = (i % 500) >= 420;
            step(1'($urandom % 2), ($urandom % 8) == 0, ($urandom % 16) != 0);
        end
        ctl_stuck = 1'b0;

        // Reset in the middle of a handshake.
        guard = 0;
        while (m_st != ST_REQ_HS && guard < 300) begin
            step(1'b0, 1'b0, 1'b1);
            guard++;
        end
        chk("mid_req_hs", 32'(state_o), 32'(ST_REQ_HS));
        do_reset();
        step(1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
